// File: rtl/simd_mac_pipe.sv
// Pipelined SIMD multiply-accumulate: LANES independent BW-bit unsigned lanes.
// Latency: two register stages (products in S1; sum, reduce and accumulator in S2).
// Backpressure: a stalled output freezes both stages; in_ready = !out_valid || out_ready.
module simd_mac_pipe #(
  parameter int BW    = 8,
  parameter int LANES = 4,
  parameter int SAT   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            mode,
  input  logic                  acc_clr,
  input  logic [LANES*BW-1:0]   din_a,
  input  logic [LANES*BW-1:0]   din_b,
  input  logic [LANES*BW-1:0]   din_c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*BW-1:0]   dout
);

  // Product width, and the working width that holds acc + a*b (or a*b + c) without overflow.
  localparam int PW = 2 * BW;
  localparam int FW = 2 * BW + 2;

  logic                  en;
  logic                  s1_valid;
  logic [2:0]            s1_mode;
  logic                  s1_clr;
  logic [LANES*BW-1:0]   s1_a;
  logic [LANES*BW-1:0]   s1_b;
  logic [LANES*BW-1:0]   s1_c;
  logic [LANES*PW-1:0]   s1_prod;
  logic [LANES*PW-1:0]   prod;
  logic [BW-1:0]         acc     [LANES];
  logic [BW-1:0]         acc_nxt [LANES];
  logic [LANES*BW-1:0]   res;

  // Working variables for the per-lane S2 arithmetic.
  logic [FW-1:0]         fa;
  logic [FW-1:0]         fb;
  logic [FW-1:0]         fc;
  logic [FW-1:0]         fp;
  logic [FW-1:0]         fs;
  logic [FW-1:0]         full;
  logic [BW-1:0]         red;

  // The whole pipeline advances together; it only stops when a result is stuck at the output.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Full-precision per-lane products of the incoming operands.
  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i*PW +: PW] = PW'(din_a[i*BW +: BW]) * PW'(din_b[i*BW +: BW]);
    end
  end

  // S1: capture products, operands and control for the beat being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 3'd0;
      s1_clr   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_prod  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_mode  <= mode;
      s1_clr   <= acc_clr;
      s1_a     <= din_a;
      s1_b     <= din_b;
      s1_c     <= din_c;
      s1_prod  <= prod;
    end
  end

  // S2 combinational: per-lane add, reduction to BW bits and next accumulator value.
  always_comb begin
    res  = '0;
    fa   = '0;
    fb   = '0;
    fc   = '0;
    fp   = '0;
    fs   = '0;
    full = '0;
    red  = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_nxt[i] = acc[i];
    end
    for (int i = 0; i < LANES; i++) begin
      fa = FW'(s1_a[i*BW +: BW]);
      fb = FW'(s1_b[i*BW +: BW]);
      fc = FW'(s1_c[i*BW +: BW]);
      fp = FW'(s1_prod[i*PW +: PW]);
      // acc_clr only matters to the accumulate modes, which are the only users of fs.
      fs = s1_clr ? '0 : FW'(acc[i]);
      case (s1_mode)
        3'b000:         full = fa + fb;
        3'b001:         full = fp + fc;
        3'b010, 3'b011: full = fp;
        3'b100:         full = fs + fp;
        3'b101:         full = fs + fa + fb;
        default:        full = fc;
      endcase
      if (SAT != 0 && full[FW-1:BW] != '0) begin
        red = '1;
      end else begin
        red = full[BW-1:0];
      end
      res[i*BW +: BW] = red;
      if (s1_mode[2]) begin
        acc_nxt[i] = red;
      end
    end
  end

  // S2 register: result, output valid and accumulators; bubbles leave dout and acc untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc[i] <= '0;
      end
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dout <= res;
        for (int i = 0; i < LANES; i++) begin
          acc[i] <= acc_nxt[i];
        end
      end
    end
  end

endmodule
